pi1_sram_resp: RTL and testbench
================================

Name: pi1_sram_resp

Overview:
- PI1 responder (slave) terminating the 2-bit-op PI1 interface driven by the PU/cpu side (pi1b or pi1q slave port).
- Holds a word-addressed on-chip RAM with byte-lane writes, atomic read-write swap and a programmable wait-state count.
- Used as boot RAM / scratchpad and as the reference slave for PI1 master verification.

Parameters:
ARCHBITSZ, 32, data width in bits; one of 16/32/64.
SIZE, 1024, RAM depth in ARCHBITSZ words; power of two, >=2.
WAITCYCLES, 0, cycles pi1_rdy_o is held low after accepting an op; 0..15.
ADDRBITSZ, ARCHBITSZ-clog2(ARCHBITSZ/8), derived word-address width; not overridden.

Ports:
clk_i  in  1  clock; all state changes on rising edge.
rst_i  in  1  asynchronous active-low reset.
pi1_op_i  in  2  0=NOOP, 1=WROP, 2=RDOP, 3=RWOP (swap).
pi1_addr_i  in  ADDRBITSZ  word address.
pi1_data_i  in  ARCHBITSZ  write data.
pi1_data_o  out  ARCHBITSZ  read data.
pi1_sel_i  in  ARCHBITSZ/8  byte-lane enables; sel[i] covers data[8i+7:8i].
pi1_rdy_o  out  1  responder ready / op accepted.
err_o  out  1  sticky out-of-range access flag.

Behaviour:
- Reset (rst_i=0, asynchronous): pi1_rdy_o=1, pi1_data_o=0, err_o=0, state=IDLE, wait counter=0. Any in-flight op is aborted with no RAM write. RAM contents are not reset.
- Acceptance: op accepted at a rising edge where pi1_rdy_o=1 and pi1_op_i!=0. At that edge op, addr, data and sel are captured. NOOP is never accepted.
- States:
  - IDLE: pi1_rdy_o=1.
  - WAIT: pi1_rdy_o=0, counter counts down.
- WAITCYCLES=0:
  - Access is performed at the accepting edge; state stays IDLE.
  - Back-to-back ops complete one per cycle.
  - pi1_data_o is valid in the cycle following acceptance.
- WAITCYCLES=W>0:
  - Accepting edge moves to WAIT with counter=W-1; pi1_rdy_o drops for exactly W cycles.
  - The access happens at the edge where the counter is 0 in WAIT. That edge returns to IDLE.
  - pi1_data_o is valid in the first cycle pi1_rdy_o is high again.
  - Inputs are ignored while in WAIT; the captured values are used.
- Ops:
  - RDOP: pi1_data_o <= mem[idx]. sel is ignored (full word returned).
  - WROP: mem[idx] byte lanes with sel[i]=1 <= data lanes. pi1_data_o unchanged.
  - RWOP: pi1_data_o <= old mem[idx], and mem[idx] is merged with the captured data per sel, in the same edge (atomic). The returned value is the pre-write word.
  - sel=0 write or swap: RAM unchanged, op still completes normally.
- Address: idx=addr[clog2(SIZE)-1:0].
- Out of range (addr>=SIZE):
  - Read/swap returns 0 and performs no write; write is ignored.
  - err_o<=1 at the access edge and stays 1 until reset.
  - Timing is identical to an in-range op.
- pi1_data_o holds its last value until the next RDOP/RWOP completes.
- Same address accessed back-to-back with W=0: the second op sees the first op's write (no stale read).

Test Plan:
(ARCHBITSZ=32, SIZE=16, WAITCYCLES=2 unless stated)
- Reset, then WROP addr=3 data=0xDEADBEEF sel=0xF, then RDOP addr=3 -> rdy_o low exactly 2 cycles after each accept; data_o=0xDEADBEEF on the cycle rdy_o returns high.
- Byte lanes: WROP addr=5 0x11223344 sel=0xF, then WROP addr=5 0xAABBCCDD sel=0x5, RDOP addr=5 -> data_o=0x11BB33DD.
- Swap: mem[7]=0x00000001; RWOP addr=7 data=0x00000002 sel=0xF -> data_o=0x00000001; subsequent RDOP addr=7 -> 0x00000002.
- Out of range: RDOP addr=16 -> data_o=0, err_o=1 from the access edge; WROP addr=20 leaves mem[4] unchanged; err_o remains 1 until rst_i=0.
- WAITCYCLES=0 streaming: WROP addr=0..3 on consecutive cycles, then RDOP addr=3 immediately after the last write -> rdy_o never drops; read returns the value just written.
- Reset mid-op: accept WROP addr=2 data=0x55 sel=0xF, assert rst_i=0 during WAIT -> rdy_o=1 and data_o=0 immediately; RDOP addr=2 afterwards returns the prior contents, not 0x55.

Source files
------------

// File: rtl/pi1_sram_resp.sv
// PI1 responder backed by a word-addressed on-chip RAM with byte-lane writes,
// atomic read/write swap and a fixed number of wait states per access.
module pi1_sram_resp #(
  parameter int ARCHBITSZ  = 32,
  parameter int SIZE       = 1024,
  parameter int WAITCYCLES = 0,
  parameter int ADDRBITSZ  = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             pi1_op_i,
  input  logic [ADDRBITSZ-1:0]   pi1_addr_i,
  input  logic [ARCHBITSZ-1:0]   pi1_data_i,
  output logic [ARCHBITSZ-1:0]   pi1_data_o,
  input  logic [ARCHBITSZ/8-1:0] pi1_sel_i,
  output logic                   pi1_rdy_o,
  output logic                   err_o
);

  localparam int SELBITSZ = ARCHBITSZ/8;
  localparam int IDXBITSZ = $clog2(SIZE);
  localparam logic [1:0] OP_NOOP = 2'd0;

  logic [ARCHBITSZ-1:0] mem [SIZE];

  // The access edge and the operands used there; with wait states these come
  // from the capture registers, otherwise straight from the bus.
  logic                 fire;
  logic [1:0]           acc_op;
  logic [ADDRBITSZ-1:0] acc_addr;
  logic [ARCHBITSZ-1:0] acc_data;
  logic [SELBITSZ-1:0]  acc_sel;
  logic                 in_range;
  logic [IDXBITSZ-1:0]  idx;

  generate
    if (WAITCYCLES == 0) begin : gen_nowait
      assign pi1_rdy_o = 1'b1;
      // Gated by reset so a held-off bus cannot write RAM while in reset.
      assign fire      = rst_i && (pi1_op_i != OP_NOOP);
      assign acc_op    = pi1_op_i;
      assign acc_addr  = pi1_addr_i;
      assign acc_data  = pi1_data_i;
      assign acc_sel   = pi1_sel_i;
    end else begin : gen_wait
      typedef enum logic {ST_IDLE, ST_WAIT} state_t;

      state_t               state_reg;
      logic [3:0]           cnt_reg;
      logic                 rdy_reg;
      logic [1:0]           op_reg;
      logic [ADDRBITSZ-1:0] addr_reg;
      logic [ARCHBITSZ-1:0] data_reg;
      logic [SELBITSZ-1:0]  sel_reg;

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
          rdy_reg   <= 1'b1;
          op_reg    <= OP_NOOP;
          addr_reg  <= '0;
          data_reg  <= '0;
          sel_reg   <= '0;
        end else begin
          case (state_reg)
            ST_IDLE: begin
              if (pi1_op_i != OP_NOOP) begin
                op_reg    <= pi1_op_i;
                addr_reg  <= pi1_addr_i;
                data_reg  <= pi1_data_i;
                sel_reg   <= pi1_sel_i;
                cnt_reg   <= 4'(WAITCYCLES - 1);
                rdy_reg   <= 1'b0;
                state_reg <= ST_WAIT;
              end
            end
            ST_WAIT: begin
              if (cnt_reg == 4'd0) begin
                rdy_reg   <= 1'b1;
                state_reg <= ST_IDLE;
              end else begin
                cnt_reg <= cnt_reg - 4'd1;
              end
            end
            default: state_reg <= ST_IDLE;
          endcase
        end
      end

      assign pi1_rdy_o = rdy_reg;
      assign fire      = (state_reg == ST_WAIT) && (cnt_reg == 4'd0);
      assign acc_op    = op_reg;
      assign acc_addr  = addr_reg;
      assign acc_data  = data_reg;
      assign acc_sel   = sel_reg;
    end

    if (IDXBITSZ >= ADDRBITSZ) begin : gen_full_range
      assign in_range = 1'b1;
    end else begin : gen_part_range
      assign in_range = ~|acc_addr[ADDRBITSZ-1:IDXBITSZ];
    end
  endgenerate

  assign idx = acc_addr[IDXBITSZ-1:0];

  // op[0] set means the op writes (WROP, RWOP); op[1] set means it reads.
  always_ff @(posedge clk_i) begin
    if (fire && in_range && acc_op[0]) begin
      for (int i = 0; i < SELBITSZ; i++) begin
        if (acc_sel[i])
          mem[idx][8*i +: 8] <= acc_data[8*i +: 8];
      end
    end
  end

  logic [ARCHBITSZ-1:0] rdata_reg;
  logic                 err_reg;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else if (fire) begin
      if (!in_range)
        err_reg <= 1'b1;
      // Non-blocking read of mem returns the pre-write word on a swap.
      if (acc_op[1])
        rdata_reg <= in_range ? mem[idx] : '0;
    end
  end

  assign pi1_data_o = rdata_reg;
  assign err_o      = err_reg;

endmodule

// File: tb/tb_pi1_sram_resp.sv
// Bench for pi1_sram_resp: a wait-state instance (W=2) and a zero-wait instance,
// both checked against an array-based model of the responder.
module tb_pi1_sram_resp;

  localparam int AW    = 30;
  localparam int DW    = 32;
  localparam int SW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [1:0]    op_d    [2];
  logic [AW-1:0] addr_d  [2];
  logic [DW-1:0] wdata_d [2];
  logic [DW-1:0] rdata_d [2];
  logic [SW-1:0] sel_d   [2];
  logic          rdy_d   [2];
  logic          err_d   [2];

  // Index 0: two wait states. Index 1: no wait states.
  pi1_sram_resp #(.ARCHBITSZ(DW), .SIZE(DEPTH), .WAITCYCLES(2)) dut_slow (
    .clk_i(clk), .rst_i(rst_n), .pi1_op_i(op_d[0]), .pi1_addr_i(addr_d[0]),
    .pi1_data_i(wdata_d[0]), .pi1_data_o(rdata_d[0]), .pi1_sel_i(sel_d[0]),
    .pi1_rdy_o(rdy_d[0]), .err_o(err_d[0])
  );

  pi1_sram_resp #(.ARCHBITSZ(DW), .SIZE(DEPTH), .WAITCYCLES(0)) dut_fast (
    .clk_i(clk), .rst_i(rst_n), .pi1_op_i(op_d[1]), .pi1_addr_i(addr_d[1]),
    .pi1_data_i(wdata_d[1]), .pi1_data_o(rdata_d[1]), .pi1_sel_i(sel_d[1]),
    .pi1_rdy_o(rdy_d[1]), .err_o(err_d[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] mdl_mem  [2][DEPTH];
  logic [DW-1:0] mdl_data [2];
  logic          mdl_err  [2];

  function automatic void model_op(input int d, input logic [1:0] op, input logic [AW-1:0] addr,
                                   input logic [DW-1:0] data, input logic [SW-1:0] sel);
    logic [DW-1:0] word;
    if (op == 2'd0) return;
    if (addr >= AW'(DEPTH)) begin
      mdl_err[d] = 1'b1;
      if (op != 2'd1) mdl_data[d] = '0;
    end else begin
      word = mdl_mem[d][addr[3:0]];
      if (op != 2'd1) mdl_data[d] = word;
      if (op != 2'd2) begin
        for (int i = 0; i < SW; i++)
          if (sel[i]) word[8*i +: 8] = data[8*i +: 8];
        mdl_mem[d][addr[3:0]] = word;
      end
    end
  endfunction

  task automatic slow_op(input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [SW-1:0] sel);
    int   n;
    logic err_before;
    @(negedge clk);
    check("slow_rdy_before", rdy_d[0], 1'b1);
    op_d[0] = op; addr_d[0] = addr; wdata_d[0] = data; sel_d[0] = sel;
    err_before = mdl_err[0];
    model_op(0, op, addr, data, sel);
    @(posedge clk);
    @(negedge clk);
    n = 0;
    while (rdy_d[0] !== 1'b1 && n < 20) begin
      n++;
      check("slow_err_in_wait", err_d[0], err_before);
      op_d[0]    = 2'($urandom_range(0, 3));
      addr_d[0]  = AW'($urandom_range(0, 31));
      wdata_d[0] = $urandom;
      sel_d[0]   = SW'($urandom);
      @(negedge clk);
    end
    op_d[0] = 2'd0;
    check("slow_rdy_low_cycles", n, 2);
    check("slow_data", rdata_d[0], mdl_data[0]);
    check("slow_err", err_d[0], mdl_err[0]);
    $display("slow op=%0d addr=%0d data=%h sel=%h -> rdata=%h err=%0d",
             op, addr, data, sel, rdata_d[0], err_d[0]);
  endtask

  // Called at a negedge: checks the previous op's result, then drives the next.
  task automatic fast_op(input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [SW-1:0] sel);
    check("fast_rdy", rdy_d[1], 1'b1);
    check("fast_data", rdata_d[1], mdl_data[1]);
    check("fast_err", err_d[1], mdl_err[1]);
    op_d[1] = op; addr_d[1] = addr; wdata_d[1] = data; sel_d[1] = sel;
    model_op(1, op, addr, data, sel);
    $display("fast op=%0d addr=%0d data=%h sel=%h (prev rdata=%h err=%0d)",
             op, addr, data, sel, rdata_d[1], err_d[1]);
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_rdy"}, rdy_d[d], 1'b1);
      check({tag, "_data"}, rdata_d[d], '0);
      check({tag, "_err"}, err_d[d], 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] last_wr;
    for (int d = 0; d < 2; d++) begin
      op_d[d] = 2'd0; addr_d[d] = '0; wdata_d[d] = '0; sel_d[d] = '0;
      mdl_data[d] = '0; mdl_err[d] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_checks("reset");
    rst_n = 1'b1;

    // Fill the wait-state RAM so every later read has a known expectation.
    for (int a = 0; a < DEPTH; a++) slow_op(2'd1, AW'(a), $urandom, 4'hF);

    slow_op(2'd1, 30'd3, 32'hDEADBEEF, 4'hF);
    slow_op(2'd2, 30'd3, 32'h0, 4'h0);
    check("tp_rd_deadbeef", rdata_d[0], 32'hDEADBEEF);

    slow_op(2'd1, 30'd5, 32'h11223344, 4'hF);
    slow_op(2'd1, 30'd5, 32'hAABBCCDD, 4'h5);
    slow_op(2'd2, 30'd5, 32'h0, 4'h0);
    check("tp_byte_lanes", rdata_d[0], 32'h11BB33DD);

    slow_op(2'd1, 30'd7, 32'h1, 4'hF);
    slow_op(2'd3, 30'd7, 32'h2, 4'hF);
    check("tp_swap_old", rdata_d[0], 32'h1);
    slow_op(2'd2, 30'd7, 32'h0, 4'hF);
    check("tp_swap_new", rdata_d[0], 32'h2);

    slow_op(2'd2, 30'd16, 32'h0, 4'hF);
    check("tp_oor_data", rdata_d[0], 32'h0);
    check("tp_oor_err", err_d[0], 1'b1);
    slow_op(2'd1, 30'd20, 32'hCAFEF00D, 4'hF);
    slow_op(2'd2, 30'd4, 32'h0, 4'hF);
    check("tp_oor_err_sticky", err_d[0], 1'b1);

    for (int k = 0; k < 40; k++)
      slow_op(2'($urandom_range(1, 3)), AW'($urandom_range(0, 19)), $urandom, SW'($urandom));

    @(negedge clk);
    for (int a = 0; a < DEPTH; a++) fast_op(2'd1, AW'(a), $urandom, 4'hF);
    last_wr = '0;
    for (int a = 0; a < 4; a++) begin
      last_wr = $urandom;
      fast_op(2'd1, AW'(a), last_wr, 4'hF);
    end
    fast_op(2'd2, 30'd3, 32'h0, 4'h0);
    fast_op(2'd0, 30'd0, 32'h0, 4'h0);
    check("tp_stream_rd_after_wr", rdata_d[1], last_wr);
    for (int k = 0; k < 60; k++)
      fast_op(2'($urandom_range(0, 3)), AW'($urandom_range(0, 19)), $urandom, SW'($urandom));
    fast_op(2'd0, 30'd0, 32'h0, 4'h0);

    // Abort a write in its wait state; the old contents must survive.
    @(negedge clk);
    op_d[0] = 2'd1; addr_d[0] = 30'd2; wdata_d[0] = 32'h55; sel_d[0] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    op_d[0] = 2'd0;
    check("tp_midop_in_wait", rdy_d[0], 1'b0);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      mdl_data[d] = '0;
      mdl_err[d]  = 1'b0;
    end
    reset_checks("midop_reset");
    @(negedge clk);
    rst_n = 1'b1;
    slow_op(2'd2, 30'd2, 32'h0, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
